// File: rtl/p_mul_gather_pkg.sv
// Shared number-format types and helpers for the multiply/gather stage.
// Formats are INT or FXP, signed or unsigned, up to 31 bits of precision.
package p_mul_gather_pkg;

  typedef enum logic [0:0] {
    INT = 1'b0,
    FXP = 1'b1
  } dtype_t;

  typedef struct packed {
    dtype_t     dtype;
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  localparam dconf_t DCONF_INT8 = '{dtype: INT, sign: 1'b1, prec: 8'd8, frac: 8'd0};

  function automatic longint fmt_max(input dconf_t c);
    return c.sign ? (64'sd1 <<< (c.prec - 8'd1)) - 64'sd1 : (64'sd1 <<< c.prec) - 64'sd1;
  endfunction

  function automatic longint fmt_min(input dconf_t c);
    return c.sign ? -(64'sd1 <<< (c.prec - 8'd1)) : 64'sd0;
  endfunction

  // INT formats ignore the configured fraction width.
  function automatic int unsigned eff_frac(input dconf_t c);
    return (c.dtype == FXP) ? 32'(c.frac) : 32'd0;
  endfunction

endpackage

// File: rtl/p_mul_gather_mul.sv
// p_mul: combinational saturating multiplier in a configurable INT/FXP format.
// Products are floored (toward -inf) by the fraction width, then clamped.
module p_mul
  import p_mul_gather_pkg::*;
#(
  parameter dconf_t CONF = DCONF_INT8
) (
  input  logic [CONF.prec-1:0] a,
  input  logic [CONF.prec-1:0] b,
  output logic [CONF.prec-1:0] out,
  output logic                 ovf,
  output logic                 udf,
  output logic                 rounded
);

  localparam int unsigned PREC = 32'(CONF.prec);
  localparam int unsigned PW   = 2 * PREC + 1;
  localparam int unsigned FRAC = eff_frac(CONF);
  localparam logic signed [PW-1:0] MAXV  = PW'(fmt_max(CONF));
  localparam logic signed [PW-1:0] MINV  = PW'(fmt_min(CONF));
  localparam logic        [PW-1:0] FMASK = (PW'(1) << FRAC) - PW'(1);

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shf;

  // One spare bit keeps full unsigned products positive in signed arithmetic.
  always_comb begin
    a_x     = CONF.sign ? PW'(signed'(a)) : PW'(a);
    b_x     = CONF.sign ? PW'(signed'(b)) : PW'(b);
    prod    = a_x * b_x;
    shf     = prod >>> FRAC;
    rounded = |(prod & FMASK);
    ovf     = 1'b0;
    udf     = 1'b0;
    out     = shf[PREC-1:0];
    if (shf > MAXV) begin
      out = MAXV[PREC-1:0];
      ovf = 1'b1;
    end else if (shf < MINV) begin
      out = MINV[PREC-1:0];
      udf = 1'b1;
    end
  end

endmodule

// File: rtl/p_mul_gather.sv
// p_mul_gather: multiplies (input, weight) pairs and packs IN products per
// output vector with sticky imprecision flags, feeding p_acc.
module p_mul_gather
  import p_mul_gather_pkg::*;
#(
  parameter int unsigned IN   = 5,
  parameter dconf_t      CONF = DCONF_INT8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CONF.prec-1:0]       in_data,
  input  logic [CONF.prec-1:0]       in_weight,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IN*CONF.prec-1:0]    out_vec,
  output logic [$clog2(IN+1)-1:0]    out_cnt,
  output logic                       ovf,
  output logic                       udf,
  output logic                       rounded
);

  localparam int unsigned PREC = 32'(CONF.prec);
  localparam int unsigned IW   = $clog2(IN);
  localparam int unsigned CW   = $clog2(IN + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IN*PREC-1:0] vec_q, vec_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               rnd_q, rnd_d;

  logic [PREC-1:0]    prod;
  logic               p_ovf, p_udf, p_rnd;
  logic               accept;

  p_mul #(.CONF(CONF)) u_mul (
    .a       (in_data),
    .b       (in_weight),
    .out     (prod),
    .ovf     (p_ovf),
    .udf     (p_udf),
    .rounded (p_rnd)
  );

  // Consume clears the vector first so a same-cycle accept starts a fresh one.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    rnd_d    = rnd_q;
    in_ready = (state_q == FILL) ? 1'b1 : out_ready;
    accept   = in_valid && in_ready;

    if (state_q == FULL && out_ready) begin
      state_d = FILL;
      valid_d = 1'b0;
      vec_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      rnd_d   = 1'b0;
    end

    if (accept) begin
      vec_d[32'(idx_q)*PREC +: PREC] = prod;
      ovf_d = ovf_d | p_ovf;
      udf_d = udf_d | p_udf;
      rnd_d = rnd_d | p_rnd;
      if (idx_q == IW'(IN - 1) || in_last) begin
        state_d = FULL;
        valid_d = 1'b1;
        cnt_d   = CW'(idx_q) + CW'(1);
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      rnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_vec   = vec_q;
  assign out_cnt   = cnt_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign rounded   = rnd_q;

endmodule

// File: tb/tb_p_mul_gather.sv
// Bench for p_mul_gather: three formats (signed INT8, FXP16 frac 4, unsigned INT8)
// share handshake controls and are scored against an arithmetic reference model.
module tb_p_mul_gather;
  import p_mul_gather_pkg::*;

  localparam int unsigned IN = 5;
  localparam dconf_t C0 = '{dtype: INT, sign: 1'b1, prec: 8'd8,  frac: 8'd0};
  localparam dconf_t C1 = '{dtype: FXP, sign: 1'b1, prec: 8'd16, frac: 8'd4};
  localparam dconf_t C2 = '{dtype: INT, sign: 1'b0, prec: 8'd8,  frac: 8'd0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_last, out_ready;
  logic [15:0] da [3];
  logic [15:0] dw [3];
  logic        rdy [3];
  logic        ov  [3];
  logic        o_f [3];
  logic        u_f [3];
  logic        r_f [3];
  logic [2:0]  cnt [3];
  logic [39:0] vec0, vec2;
  logic [79:0] vec1;
  logic [79:0] vec_o [3];

  assign vec_o[0] = 80'(vec0);
  assign vec_o[1] = vec1;
  assign vec_o[2] = 80'(vec2);

  p_mul_gather #(.IN(IN), .CONF(C0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(da[0][7:0]), .in_weight(dw[0][7:0]), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_vec(vec0), .out_cnt(cnt[0]),
    .ovf(o_f[0]), .udf(u_f[0]), .rounded(r_f[0])
  );

  p_mul_gather #(.IN(IN), .CONF(C1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(da[1]), .in_weight(dw[1]), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_vec(vec1), .out_cnt(cnt[1]),
    .ovf(o_f[1]), .udf(u_f[1]), .rounded(r_f[1])
  );

  p_mul_gather #(.IN(IN), .CONF(C2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(da[2][7:0]), .in_weight(dw[2][7:0]), .in_last(in_last),
    .out_valid(ov[2]), .out_ready(out_ready), .out_vec(vec2), .out_cnt(cnt[2]),
    .ovf(o_f[2]), .udf(u_f[2]), .rounded(r_f[2])
  );

  dconf_t cfg [3];
  int checks = 0;
  int failures = 0;

  // Reference model: one vector being built, one completed vector awaiting pickup.
  bit          pending;
  int          n;
  logic [15:0] cur [3][IN];
  logic [15:0] ex  [3][IN];
  int          ex_cnt;
  bit          bf_o [3], bf_u [3], bf_r [3];
  bit          ex_o [3], ex_u [3], ex_r [3];
  logic [79:0] held;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic void mmul(input dconf_t c, input logic [15:0] x, input logic [15:0] y,
                               output logic [15:0] r, output bit o, output bit u, output bit rd);
    longint p_w, m, vx, vy, p, d, q, rem, hi, lo;
    p_w = longint'(c.prec);
    m   = (64'sd1 << p_w) - 1;
    vx  = longint'(x) & m;
    vy  = longint'(y) & m;
    if (c.sign && vx >= (64'sd1 << (p_w - 1))) vx -= (64'sd1 << p_w);
    if (c.sign && vy >= (64'sd1 << (p_w - 1))) vy -= (64'sd1 << p_w);
    p   = vx * vy;
    d   = (c.dtype == FXP) ? (64'sd1 << longint'(c.frac)) : 64'sd1;
    q   = p / d;
    rem = p % d;
    if (rem != 0 && p < 0) q -= 1;
    rd  = (rem != 0);
    hi  = c.sign ? (64'sd1 << (p_w - 1)) - 1 : m;
    lo  = c.sign ? -(64'sd1 << (p_w - 1)) : 64'sd0;
    o   = (q > hi);
    u   = (q < lo);
    if (o) q = hi;
    if (u) q = lo;
    r   = 16'(q & m);
  endfunction

  function automatic void clear_model();
    pending = 0;
    n       = 0;
    ex_cnt  = 0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < IN; s++) begin
        cur[k][s] = '0;
        ex[k][s]  = '0;
      end
      bf_o[k] = 0; bf_u[k] = 0; bf_r[k] = 0;
      ex_o[k] = 0; ex_u[k] = 0; ex_r[k] = 0;
    end
  endfunction

  // Check outputs against the model, then advance DUT and model by one clock.
  task automatic cycle();
    logic [79:0] e;
    logic [15:0] p;
    bit          acc, cons, exp_rdy, o, u, r;
    #1;
    exp_rdy = !pending || out_ready;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      for (int s = 0; s < IN; s++)
        e |= 80'(pending ? ex[k][s] : cur[k][s]) << (s * int'(cfg[k].prec));
      chk($sformatf("in_ready%0d", k), 80'(rdy[k]), 80'(exp_rdy));
      chk($sformatf("out_valid%0d", k), 80'(ov[k]), 80'(pending));
      chk($sformatf("out_vec%0d", k), vec_o[k], e);
      chk($sformatf("flags%0d", k), 80'({o_f[k], u_f[k], r_f[k]}),
          pending ? 80'({ex_o[k], ex_u[k], ex_r[k]}) : 80'({bf_o[k], bf_u[k], bf_r[k]}));
      if (pending) chk($sformatf("out_cnt%0d", k), 80'(cnt[k]), 80'(ex_cnt));
    end
    acc  = in_valid && exp_rdy;
    cons = pending && out_ready;
    @(posedge clk);
    if (cons) pending = 0;
    if (acc) begin
      for (int k = 0; k < 3; k++) begin
        mmul(cfg[k], da[k], dw[k], p, o, u, r);
        cur[k][n] = p;
        bf_o[k] |= o; bf_u[k] |= u; bf_r[k] |= r;
      end
      n++;
      if (n == IN || in_last) begin
        pending = 1;
        ex_cnt  = n;
        for (int k = 0; k < 3; k++) begin
          ex[k] = cur[k];
          ex_o[k] = bf_o[k]; ex_u[k] = bf_u[k]; ex_r[k] = bf_r[k];
          for (int s = 0; s < IN; s++) cur[k][s] = '0;
          bf_o[k] = 0; bf_u[k] = 0; bf_r[k] = 0;
        end
        n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit l, input bit r,
                       input int a0, input int b0, input int a1, input int b1,
                       input int a2, input int b2);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    da[0] = 16'(a0); dw[0] = 16'(b0);
    da[1] = 16'(a1); dw[1] = 16'(b1);
    da[2] = 16'(a2); dw[2] = 16'(b2);
    cycle();
  endtask

  task automatic drive0(input bit v, input bit l, input bit r, input int a0, input int b0);
    drive(v, l, r, a0, b0, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
  endtask

  task automatic do_reset();
    in_valid  = 0;
    in_last   = 0;
    out_ready = 0;
    reset     = 1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid%0d", k), 80'(ov[k]), 80'(0));
      chk($sformatf("rst_out_vec%0d", k), vec_o[k], 80'(0));
      chk($sformatf("rst_out_cnt%0d", k), 80'(cnt[k]), 80'(0));
      chk($sformatf("rst_flags%0d", k), 80'({o_f[k], u_f[k], r_f[k]}), 80'(0));
      chk($sformatf("rst_in_ready%0d", k), 80'(rdy[k]), 80'(1));
    end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    cfg[0] = C0; cfg[1] = C1; cfg[2] = C2;
    clear_model();
    reset = 1;
    in_valid = 0; in_last = 0; out_ready = 0;
    for (int k = 0; k < 3; k++) begin da[k] = '0; dw[k] = '0; end
    @(negedge clk);
    do_reset();

    // Reset mid-fill discards the partial vector.
    for (int i = 0; i < 3; i++) drive0(1, 0, 1, 9, 9);
    do_reset();
    for (int i = 0; i < 5; i++) drive0(1, 0, 1, i + 1, 1);
    chk("refill_vec", vec_o[0], 80'(40'h0504030201));

    // Signed INT8 back-to-back vector.
    drive0(1, 0, 1, 1, 2);
    drive0(1, 0, 1, 3, 4);
    drive0(1, 0, 1, -2, 5);
    drive0(1, 0, 1, 0, 7);
    drive0(1, 0, 1, 6, -1);
    chk("int8_vec", vec_o[0], 80'(40'hFA00F60C02));
    chk("int8_cnt", 80'(cnt[0]), 80'(5));
    chk("int8_flags", 80'({o_f[0], u_f[0], r_f[0]}), 80'(0));

    // Saturation both ways with a short vector.
    drive0(1, 0, 1, 100, 2);
    drive0(1, 1, 1, -100, 2);
    chk("sat_vec", vec_o[0], 80'(40'h000000807F));
    chk("sat_cnt", 80'(cnt[0]), 80'(2));
    chk("sat_flags", 80'({o_f[0], u_f[0]}), 80'(2'b11));

    // Backpressure, then same-cycle handoff.
    drive0(1, 0, 1, 5, 5);
    drive0(1, 1, 1, 1, 1);
    held = vec_o[0];
    for (int i = 0; i < 4; i++) drive0(1, 0, 0, 7, 7);
    chk("bp_in_ready", 80'(rdy[0]), 80'(0));
    chk("bp_hold_vec", vec_o[0], held);
    drive0(1, 0, 1, 3, 3);
    chk("handoff_slot0", 80'(vec0[7:0]), 80'(9));
    chk("handoff_flags", 80'({o_f[0], u_f[0], r_f[0]}), 80'(0));
    chk("handoff_valid", 80'(ov[0]), 80'(0));
    drive0(1, 1, 1, 0, 0);

    // FXP16 frac 4 and unsigned INT8, single-pair vectors.
    drive(1, 1, 1, 1, 1, 16'h0018, 16'h0008, 20, 20);
    chk("fxp_a", 80'(vec1[15:0]), 80'(16'h000C));
    chk("fxp_a_flags", 80'({o_f[1], u_f[1], r_f[1]}), 80'(3'b000));
    chk("uns_vec", vec_o[2], 80'(40'h00000000FF));
    chk("uns_cnt", 80'(cnt[2]), 80'(1));
    chk("uns_flags", 80'({o_f[2], u_f[2], r_f[2]}), 80'(3'b100));
    drive(1, 1, 1, 1, 1, 16'h0001, 16'h0001, 1, 1);
    chk("fxp_b", 80'(vec1[15:0]), 80'(16'h0000));
    chk("fxp_b_flags", 80'({o_f[1], u_f[1], r_f[1]}), 80'(3'b001));
    drive(1, 1, 1, 1, 1, 16'h7000, 16'h0100, 1, 1);
    chk("fxp_c", 80'(vec1[15:0]), 80'(16'h7FFF));
    chk("fxp_c_flags", 80'({o_f[1], u_f[1], r_f[1]}), 80'(3'b100));

    // Randomized traffic scored against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) < 7,
            int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p_mul_gather.md
Name: p_mul_gather

Overview:
- Upstream feeder for p_acc.
- Accepts a stream of (input, weight) element pairs over a valid/ready handshake, one pair per cycle.
- Multiplies each pair in the configured number format (INT or FXP, selected by CONF), with saturation.
- Packs IN products into the vector that drives p_acc's `in`, and forwards per-vector imprecision flags alongside it.
- Sits between the neuron's input/weight fetch logic and p_acc.

Parameters:
- IN, 5, number of product slots per output vector (matches p_acc IN); must be >= 2.
- CONF, dconf_t'{dtype:INT, sign:`Enable, prec:8, frac:0}, number format shared by inputs, weights and products.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- in_valid  input  1  element pair present.
- in_ready  output  1  element pair accepted this cycle when in_valid && in_ready.
- in_data  input  CONF.prec  activation element.
- in_weight  input  CONF.prec  weight element.
- in_last  input  1  marks the final pair of a vector; unused slots are zero-filled.
- out_valid  output  1  packed vector available.
- out_ready  input  1  consumer (p_acc stage) takes the vector.
- out_vec  output  IN*CONF.prec  packed products; slot 0 in bits [PREC-1:0].
- out_cnt  output  $clog2(IN+1)  number of valid slots in out_vec (1..IN).
- ovf  output  1  sticky: some product in the vector saturated high.
- udf  output  1  sticky: some product in the vector saturated low.
- rounded  output  1  sticky: some product lost nonzero fraction bits.

Behaviour:
- Reset, asynchronous, any time:
  - out_valid=0, out_vec=0, out_cnt=0, ovf=udf=rounded=0.
  - Slot index idx=0, state=FILL.
  - A partially filled vector is discarded.
- States:
  - FILL: collecting products. in_ready=1.
  - FULL: vector held. in_ready=out_ready.
- Accept: on in_valid && in_ready, the product is written to slot idx, and the sticky flags are ORed with that product's flags.
  - idx==IN-1 or in_last: go to FULL, out_valid=1 next cycle, out_cnt=idx+1, remaining slots forced to 0, idx reset to 0.
  - Otherwise: idx increments.
- FULL with out_ready=1:
  - The vector is consumed.
  - If a pair is accepted in the same cycle, it becomes slot 0 of a fresh vector: flags restart from that product's flags, the other slots clear, and state returns to FILL (or stays FULL if IN==1-equivalent via in_last).
  - With no accept, go to FILL, out_valid=0, flags clear.
- FULL with out_ready=0: out_vec, out_cnt and flags are held stable; in_ready=0.
- Latency: the last accepted pair is followed by out_valid one cycle later. Throughput is one pair per cycle with no bubble when out_ready=1.
- Arithmetic:
  - Full 2*PREC-bit product (signed if CONF.sign, else unsigned).
  - FXP: arithmetic right-shift by FRAC, truncation toward -inf; rounded=1 if any discarded bit is nonzero.
  - INT: FRAC is ignored, rounded=0.
  - Saturation: result > max representable → max, ovf=1. Result < min representable (0 for unsigned) → min, udf=1.
- in_last while idx==IN-1 behaves the same as a normal full vector.
- in_last with in_valid=0 is ignored.

Decomposition:
- dtype_t, dconf_t and the format min/max helper functions come from the shared perceptron package header; no new typedefs are needed there.
- Add a localparam-based state enum (FILL/FULL) local to the module.
- One natural sub-module: p_mul, a combinational saturating multiplier with ports a, b, out, ovf, udf, rounded, parameterized by CONF. It is reusable elsewhere.

Test Plan:
1. Reset asserted mid-fill after 3 accepts, then released → out_valid=0, in_ready=1. The next 5 pairs produce a full vector with no stale slots.
2. INT8 signed, IN=5, pairs (1,2),(3,4),(-2,5),(0,7),(6,-1) fed back-to-back with out_ready=1 → one cycle after the 5th accept: out_valid=1, slots {2,12,-10,0,-6}, out_cnt=5, ovf=udf=rounded=0.
3. Pairs (100,2) then (-100,2) then in_last → slots {127,-128,0,0,0}, out_cnt=2, ovf=1, udf=1.
4. Backpressure: vector full, out_ready=0 for 4 cycles → in_ready=0 and out_vec/flags stable. Then out_ready=1 with in_valid=1, pair (3,3) → same-cycle handoff, the new vector slot 0=9, flags cleared.
5. FXP16, FRAC=4: 0x0018*0x0008 → 0x000C with rounded=0. 0x0001*0x0001 → 0x0000 with rounded=1. 0x7000*0x0100 → 0x7FFF with ovf=1.
6. Unsigned INT8: (20,20) → 255 with ovf=1. in_last on the first pair → out_cnt=1, slots 1..4 = 0.
